// File: rtl/parser_lane_dispatch_merge.sv
// N-lane dispatch/merge wrapper for the parallel parser array.
// Input bundles are broadcast to every lane and strobed into one lane at a
// time in round-robin order. Each lane's result lands in a small per-lane
// FIFO. Results are re-merged in dispatch order onto a registered
// valid/ready stream. Per-lane credits throttle the input so that a
// compliant lane can never overrun its FIFO.
module parser_lane_dispatch_merge #(
  parameter int N_LANES         = 4,
  parameter int IN_WIDTH        = 1152,
  parameter int RES_WIDTH       = 6400,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int PTR_W           = $clog2(N_LANES)
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [IN_WIDTH-1:0]            lane_in_data,
  output logic [N_LANES-1:0]             lane_in_valid,
  input  logic [N_LANES*RES_WIDTH-1:0]   lane_res_data,
  input  logic [N_LANES-1:0]             lane_res_valid,
  output logic [RES_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overflow_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N_LANES - 1);

  logic [PTR_W-1:0]     in_ptr_q, in_ptr_d;
  logic [PTR_W-1:0]     out_ptr_q, out_ptr_d;
  logic [CW-1:0]        credit_q [N_LANES];
  logic [CW-1:0]        credit_d [N_LANES];
  logic [CW-1:0]        wr_ptr_q [N_LANES];
  logic [CW-1:0]        wr_ptr_d [N_LANES];
  logic [CW-1:0]        rd_ptr_q [N_LANES];
  logic [CW-1:0]        rd_ptr_d [N_LANES];
  logic                 out_valid_q, out_valid_d;
  logic [RES_WIDTH-1:0] out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;

  logic [RES_WIDTH-1:0] fifo_mem [N_LANES][DEPTH];

  logic [N_LANES-1:0]   fifo_full;
  logic [N_LANES-1:0]   fifo_empty;
  logic [N_LANES-1:0]   fifo_wr;
  logic                 dispatch;
  logic                 load;

  // FIFO status, input acceptance, dispatch strobe and merge-load decision.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][CW-1] != rd_ptr_q[i][CW-1]) &&
                      (wr_ptr_q[i][FIFO_DEPTH_BITS-1:0] == rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]);
      // Fullness is judged before this cycle's pop, so a full FIFO being
      // drained still rejects a simultaneous write.
      fifo_wr[i]    = lane_res_valid[i] & ~fifo_full[i];
    end
    // Held low during reset even though the credits already read zero.
    in_ready = aresetn & (credit_q[in_ptr_q] < CW'(DEPTH));
    dispatch = in_valid & in_ready;
    for (int i = 0; i < N_LANES; i++) begin
      lane_in_valid[i] = dispatch && (in_ptr_q == PTR_W'(i));
    end
    load = (~out_valid_q | out_ready) & ~fifo_empty[out_ptr_q];
  end

  // Next-state for pointers, credits, FIFO indices, output register and error flag.
  always_comb begin
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | (|(lane_res_valid & fifo_full));

    if (dispatch) begin
      in_ptr_d = (in_ptr_q == LAST_LANE) ? '0 : in_ptr_q + PTR_W'(1);
    end

    for (int i = 0; i < N_LANES; i++) begin
      credit_d[i] = credit_q[i];
      wr_ptr_d[i] = wr_ptr_q[i] + CW'(fifo_wr[i]);
      rd_ptr_d[i] = rd_ptr_q[i];
      if (load && (out_ptr_q == PTR_W'(i))) begin
        rd_ptr_d[i] = rd_ptr_q[i] + CW'(1);
      end
      // A dispatch and a pop on the same lane cancel out.
      if ((dispatch && (in_ptr_q == PTR_W'(i))) && !(load && (out_ptr_q == PTR_W'(i)))) begin
        credit_d[i] = credit_q[i] + CW'(1);
      end else if (!(dispatch && (in_ptr_q == PTR_W'(i))) && (load && (out_ptr_q == PTR_W'(i)))) begin
        credit_d[i] = credit_q[i] - CW'(1);
      end
    end

    if (load) begin
      out_data_d  = fifo_mem[out_ptr_q][rd_ptr_q[out_ptr_q][FIFO_DEPTH_BITS-1:0]];
      out_valid_d = 1'b1;
      out_ptr_d   = (out_ptr_q == LAST_LANE) ? '0 : out_ptr_q + PTR_W'(1);
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      in_ptr_q    <= '0;
      out_ptr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        credit_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      in_ptr_q    <= in_ptr_d;
      out_ptr_q   <= out_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < N_LANES; i++) begin
        credit_q[i] <= credit_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LANES; i++) begin
      if (fifo_wr[i]) begin
        fifo_mem[i][wr_ptr_q[i][FIFO_DEPTH_BITS-1:0]] <= lane_res_data[i*RES_WIDTH +: RES_WIDTH];
      end
    end
  end

  assign lane_in_data = in_data;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_parser_lane_dispatch_merge.sv
// Bench for parser_lane_dispatch_merge: the bench plays the sub-parser lanes,
// keeps an item-level reference model (dispatch order, return times,
// occupancy per lane) and scoreboards the merged output stream.
module tb_parser_lane_dispatch_merge;

  localparam int N     = 4;
  localparam int IW    = 32;
  localparam int RW    = 32;
  localparam int FB    = 2;
  localparam int DEPTH = 1 << FB;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [IW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     lane_in_data;
  logic [N-1:0]      lane_in_valid;
  logic [N*RW-1:0]   lane_res_data = '0;
  logic [N-1:0]      lane_res_valid = '0;
  logic [RW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              overflow_err;

  parser_lane_dispatch_merge #(
    .N_LANES(N), .IN_WIDTH(IW), .RES_WIDTH(RW), .FIFO_DEPTH_BITS(FB)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .lane_in_data(lane_in_data), .lane_in_valid(lane_in_valid),
    .lane_res_data(lane_res_data), .lane_res_valid(lane_res_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int            due;
    int            idx;
    logic [RW-1:0] res;
  } lane_item_t;

  // Lane behaviour
  lane_item_t    lane_q [N][$];
  int            last_due [N];
  int            lane_delay [N];
  bit            lanes_auto = 1'b1;
  logic [N-1:0]  man_valid = '0;
  logic [N*RW-1:0] man_data = '0;

  // Reference model
  logic [RW-1:0] exp_q [$];
  int            ret_cyc [int];
  int            disp_cnt = 0;
  int            load_cnt = 0;
  bit            occ = 1'b0;
  bit            hold_v = 1'b0;
  logic [RW-1:0] hold_d = '0;

  function automatic logic [RW-1:0] parse_fn(input logic [IW-1:0] x);
    return RW'((x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lanes: return each item's result at its due cycle, in per-lane order.
  always @(posedge clk) begin
    lane_item_t it;
    #1;
    lane_res_valid = '0;
    lane_res_data  = '0;
    if (aresetn) begin
      if (!lanes_auto) begin
        lane_res_valid = man_valid;
        lane_res_data  = man_data;
      end else begin
        for (int l = 0; l < N; l++) begin
          if (lane_q[l].size() > 0 && lane_q[l][0].due <= cyc) begin
            it = lane_q[l].pop_front();
            lane_res_valid[l] = 1'b1;
            lane_res_data[l*RW +: RW] = it.res;
            ret_cyc[it.idx] = cyc;
          end
        end
      end
    end
  end

  // Monitor and model step, sampled mid-cycle.
  always @(negedge clk) begin
    int           l, cnt, d;
    bit           rdy, hs, ld;
    logic [N-1:0] liv;
    lane_item_t   it;
    if (aresetn) begin
      // Item k always goes to lane k % N; a lane's occupancy is its items
      // dispatched but not yet moved into the output register.
      l   = disp_cnt % N;
      cnt = 0;
      for (int k = load_cnt; k < disp_cnt; k++) if (k % N == l) cnt++;
      rdy = (cnt < DEPTH);
      hs  = in_valid && rdy;
      liv = '0;
      if (hs) liv[l] = 1'b1;
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, occ);
      chk("lane_in_valid", lane_in_valid, liv);
      if (hold_v) chk("out_data_hold", out_data, hold_d);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_data: got %0h, expected nothing (cycle %0d)", out_data, cyc);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;

      ld = (!occ || out_ready) && (load_cnt < disp_cnt) &&
           ret_cyc.exists(load_cnt) && (ret_cyc[load_cnt] < cyc);

      if (hs) begin
        chk("lane_in_data", lane_in_data, in_data);
        d = (lane_delay[l] > 0) ? lane_delay[l] : int'($urandom_range(1, 6));
        it.due = cyc + d;
        if (it.due <= last_due[l]) it.due = last_due[l] + 1;
        last_due[l] = it.due;
        it.idx = disp_cnt;
        it.res = parse_fn(in_data);
        lane_q[l].push_back(it);
        exp_q.push_back(it.res);
      end

      if (ld) occ = 1'b1;
      else if (occ && out_ready) occ = 1'b0;
      load_cnt += int'(ld);
      disp_cnt += int'(hs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    ret_cyc.delete();
    for (int l = 0; l < N; l++) begin
      lane_q[l].delete();
      last_due[l] = 0;
    end
    disp_cnt = 0;
    load_cnt = 0;
    occ      = 1'b0;
    hold_v   = 1'b0;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    in_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    aresetn = 1'b1;
    tick();
  endtask

  task automatic drain(input int max_cycles);
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() > 0 || occ) && t < max_cycles) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(output int at_cyc);
    int t;
    t = 0;
    at_cyc = -1;
    while (t < 40) begin
      @(negedge clk);
      if (out_valid) begin
        at_cyc = cyc;
        break;
      end
      t++;
    end
  endtask

  initial begin
    int ca, first, hs;
    for (int l = 0; l < N; l++) lane_delay[l] = 3;

    // Reset values
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_lane_in_valid", lane_in_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    aresetn = 1'b1;
    tick();

    // In-order dispatch, fixed 3-cycle lanes
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ca = cyc;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA000_0000 + i;
      @(negedge clk);
      chk("order_strobe", lane_in_valid, 4'b0001 << i);
      tick();
    end
    in_valid = 1'b0;
    wait_out_valid(first);
    chk("order_latency", first - ca, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("order_burst", out_valid, 1);
    end
    drain(50);

    // Lane 1 completes well before lane 0
    lane_delay[0] = 8;
    lane_delay[1] = 2;
    in_valid = 1'b1;
    in_data  = 32'hB0B0_0001;
    ca = cyc;
    tick();
    in_data  = 32'hB0B0_0002;
    tick();
    in_valid = 1'b0;
    wait_out_valid(first);
    chk("ooo_first_valid", first - ca, 10);
    @(negedge clk);
    chk("ooo_second_valid", out_valid, 1);
    drain(50);

    // Random traffic with random lane latency and downstream stalls
    for (int l = 0; l < N; l++) lane_delay[l] = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        out_ready = (ph[0]) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    drain(300);
    chk("random_no_overflow", overflow_err, 0);

    // Full backpressure: every lane FIFO fills, plus one item in the output register
    do_reset();
    for (int l = 0; l < N; l++) lane_delay[l] = 2;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    hs = 0;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) hs++;
      tick();
    end
    chk("bp_handshakes", hs, N * DEPTH + 1);
    @(negedge clk);
    chk("bp_stalled", in_ready, 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    drain(100);

    // Asynchronous reset with items in flight
    do_reset();
    for (int l = 0; l < N; l++) lane_delay[l] = 1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC0C0_0000 + i;
      tick();
    end
    in_valid = 1'b0;
    wait_out_valid(first);
    chk("midrst_setup_valid", out_valid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_overflow", overflow_err, 0);
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hD00D_0001;
    @(negedge clk);
    chk("midrst_first_lane", lane_in_valid, 4'b0001);
    tick();
    in_valid = 1'b0;
    drain(50);

    // Overflow: lane 2 returns 5 unsolicited results while nothing drains it
    do_reset();
    lanes_auto = 1'b0;
    out_ready  = 1'b0;
    for (int j = 0; j < 5; j++) begin
      man_valid = 4'b0100;
      man_data  = '0;
      man_data[2*RW +: RW] = $urandom;
      tick();
    end
    man_valid = '0;
    @(negedge clk);
    chk("ovf_after_4", overflow_err, 0);
    @(negedge clk);
    chk("ovf_after_5", overflow_err, 1);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", overflow_err, 1);
    tick();
    lanes_auto = 1'b1;
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", overflow_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
